// File: rtl/player_move_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : player_move_ctrl_if
// Description : Signal bundle between the game core / map and the player
//               movement controller. The master side (game core) drives the
//               move commands, obstacle flags and life-cycle events. The
//               slave side (player_move_ctrl) returns the player state.
// Revision    : 1.0  initial release
// ============================================================================
interface player_move_ctrl_if;
    // Commands and events towards the controller
    logic [2:0] move;       // bit2 = valid, [1:0] = up/down/left/right
    logic [3:0] blocked;    // {right, left, down, up}
    logic       dead;
    logic       respawn;

    // Player state from the controller
    logic [3:0] pos_x;
    logic [7:0] pos_y;
    logic [1:0] facing;
    logic       hop_active;
    logic [3:0] hop_phase;
    logic [9:0] score;
    logic       alive;

    modport master (
        output move, blocked, dead, respawn,
        input  pos_x, pos_y, facing, hop_active, hop_phase, score, alive
    );

    modport slave (
        input  move, blocked, dead, respawn,
        output pos_x, pos_y, facing, hop_active, hop_phase, score, alive
    );
endinterface
`default_nettype wire

// File: rtl/player_move_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : player_move_ctrl
// Description : Grid movement controller for a lane-crossing player. Accepts
//               single-cycle move commands, checks them against the map
//               edges and obstacle flags, runs a fixed-length hop animation
//               and commits the new position when the hop completes. Tracks
//               the best row reached as the score and handles death and
//               respawn.
//               Optional feature macro: PLAYER_MOVE_QUEUE_EN adds a 2-entry
//               command FIFO that buffers moves arriving during a hop.
// Revision    : 1.0  initial release
// ============================================================================
module player_move_ctrl #(
    parameter int COLS      = 9,   // lane columns, x = 0..COLS-1 (<= 16)
    parameter int START_X   = 4,   // column after reset / respawn
    parameter int HOP_TICKS = 8    // hop duration in clk_100 cycles (2..16)
) (
    input  wire logic          clk_100,
    input  wire logic          rst_n,
    player_move_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOP  = 2'd1,
        DEAD = 2'd2
    } state_t;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic [3:0] X_MAX      = 4'(COLS - 1);
    localparam logic [3:0] X_START    = 4'(START_X);
    localparam logic [3:0] PHASE_LAST = 4'(HOP_TICKS - 1);
    localparam logic [7:0] Y_MAX      = 8'hFF;

    // Local copies of the interface inputs
    logic [2:0] move;
    logic [3:0] blocked;
    logic       dead;
    logic       respawn;

    assign move    = bus.move;
    assign blocked = bus.blocked;
    assign dead    = bus.dead;
    assign respawn = bus.respawn;

    // Architectural state
    state_t     state,  state_next;
    logic [3:0] pos_x,  pos_x_next;
    logic [7:0] pos_y,  pos_y_next;
    logic [1:0] facing, facing_next;
    logic [3:0] phase,  phase_next;
    logic [9:0] score,  score_next;
    logic [3:0] tgt_x,  tgt_x_next;
    logic [7:0] tgt_y,  tgt_y_next;

    // Command evaluation helpers
    logic       cmd_valid;
    logic [1:0] cmd_dir;
    logic       cmd_ok;
    logic [3:0] cmd_x;
    logic [7:0] cmd_y;
    logic [9:0] score_cand;

`ifdef PLAYER_MOVE_QUEUE_EN
    localparam int QDEPTH = 2;

    logic [1:0] q_data      [QDEPTH];
    logic [1:0] q_data_next [QDEPTH];
    logic [1:0] q_count, q_count_next;
    logic       q_pop;
    logic       q_push;
    logic       q_flush;
    logic [1:0] q_push_dir;
`endif

    // Next-state, command evaluation and queue control for the movement FSM
    always_comb begin
        state_next  = state;
        pos_x_next  = pos_x;
        pos_y_next  = pos_y;
        facing_next = facing;
        phase_next  = phase;
        score_next  = score;
        tgt_x_next  = tgt_x;
        tgt_y_next  = tgt_y;
        cmd_valid   = 1'b0;
        cmd_dir     = move[1:0];
        cmd_ok      = 1'b0;
        cmd_x       = pos_x;
        cmd_y       = pos_y;
        // pos_y is 8 bits wide, so the best row can never pass 255 and the
        // 10-bit score saturation point is unreachable by construction.
        score_cand  = {2'b00, tgt_y};
`ifdef PLAYER_MOVE_QUEUE_EN
        q_pop       = 1'b0;
        q_push      = 1'b0;
        q_flush     = 1'b0;
        q_push_dir  = move[1:0];
`endif

        // The buffered head always takes precedence over a fresh move.
`ifdef PLAYER_MOVE_QUEUE_EN
        if (q_count != 2'd0) begin
            cmd_valid = 1'b1;
            cmd_dir   = q_data[0];
        end else begin
            cmd_valid = move[2];
        end
`else
        cmd_valid = move[2];
`endif

        // Edge legality and hop target for the selected direction
        case (cmd_dir)
            DIR_UP: begin
                cmd_ok = (pos_y != Y_MAX);
                cmd_y  = pos_y + 8'd1;
            end
            DIR_DOWN: begin
                cmd_ok = (pos_y != 8'd0);
                cmd_y  = pos_y - 8'd1;
            end
            DIR_LEFT: begin
                cmd_ok = (pos_x != 4'd0);
                cmd_x  = pos_x - 4'd1;
            end
            default: begin
                cmd_ok = (pos_x != X_MAX);
                cmd_x  = pos_x + 4'd1;
            end
        endcase
        if (blocked[cmd_dir]) begin
            cmd_ok = 1'b0;
        end

        if (dead) begin
            // Death beats everything: drop the hop, keep the position.
            state_next = DEAD;
            phase_next = 4'd0;
`ifdef PLAYER_MOVE_QUEUE_EN
            q_flush    = 1'b1;
`endif
        end else if (respawn) begin
            state_next  = IDLE;
            pos_x_next  = X_START;
            pos_y_next  = 8'd0;
            score_next  = 10'd0;
            facing_next = DIR_UP;
            phase_next  = 4'd0;
`ifdef PLAYER_MOVE_QUEUE_EN
            q_flush     = 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        // A rejected command still turns the player.
                        facing_next = cmd_dir;
                        if (cmd_ok) begin
                            state_next = HOP;
                            phase_next = 4'd0;
                            tgt_x_next = cmd_x;
                            tgt_y_next = cmd_y;
                        end
                    end
`ifdef PLAYER_MOVE_QUEUE_EN
                    // Head consumed; a same-cycle move takes its place.
                    if (q_count != 2'd0) begin
                        q_pop  = 1'b1;
                        q_push = move[2];
                    end
`endif
                end
                HOP: begin
`ifdef PLAYER_MOVE_QUEUE_EN
                    q_push = move[2];
`endif
                    if (phase == PHASE_LAST) begin
                        state_next = IDLE;
                        phase_next = 4'd0;
                        pos_x_next = tgt_x;
                        pos_y_next = tgt_y;
                        if (score_cand > score) begin
                            score_next = score_cand;
                        end
                    end else begin
                        phase_next = phase + 4'd1;
                    end
                end
                default: begin
                    // DEAD: everything held until respawn.
                    phase_next = 4'd0;
                end
            endcase
        end
    end

    // Movement FSM and player state registers
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            pos_x  <= X_START;
            pos_y  <= 8'd0;
            facing <= DIR_UP;
            phase  <= 4'd0;
            score  <= 10'd0;
            tgt_x  <= X_START;
            tgt_y  <= 8'd0;
        end else begin
            state  <= state_next;
            pos_x  <= pos_x_next;
            pos_y  <= pos_y_next;
            facing <= facing_next;
            phase  <= phase_next;
            score  <= score_next;
            tgt_x  <= tgt_x_next;
            tgt_y  <= tgt_y_next;
        end
    end

`ifdef PLAYER_MOVE_QUEUE_EN
    // Command FIFO update: flush, then pop-shift, then push if room remains
    always_comb begin
        q_data_next  = q_data;
        q_count_next = q_count;
        if (q_flush) begin
            q_count_next = 2'd0;
        end else begin
            if (q_pop) begin
                q_data_next[0] = q_data[1];
                q_count_next   = q_count - 2'd1;
            end
            if (q_push && (q_count_next < 2'(QDEPTH))) begin
                q_data_next[q_count_next[0]] = q_push_dir;
                q_count_next                 = q_count_next + 2'd1;
            end
        end
    end

    // Command FIFO storage
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            q_count   <= 2'd0;
            q_data[0] <= 2'd0;
            q_data[1] <= 2'd0;
        end else begin
            q_count   <= q_count_next;
            q_data[0] <= q_data_next[0];
            q_data[1] <= q_data_next[1];
        end
    end
`endif

    assign bus.pos_x      = pos_x;
    assign bus.pos_y      = pos_y;
    assign bus.facing     = facing;
    assign bus.hop_active = (state == HOP);
    assign bus.hop_phase  = phase;
    assign bus.score      = score;
    assign bus.alive      = (state != DEAD);

endmodule
`default_nettype wire

// File: tb/tb_player_move_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_player_move_ctrl
// Description : Self-checking bench for player_move_ctrl. Directed scenarios
//               followed by a randomized run, every cycle compared against a
//               behavioural model of the player rules.
// Revision    : 1.0  initial release
// ============================================================================
module tb_player_move_ctrl;

    localparam int COLS      = 9;
    localparam int START_X   = 4;
    localparam int HOP_TICKS = 8;
`ifdef PLAYER_MOVE_QUEUE_EN
    localparam bit QEN = 1'b1;
`else
    localparam bit QEN = 1'b0;
`endif

    logic clk_100 = 1'b0;
    logic rst_n   = 1'b0;
    int   tests   = 0;
    int   fails   = 0;

    player_move_ctrl_if bus();

    player_move_ctrl #(
        .COLS      (COLS),
        .START_X   (START_X),
        .HOP_TICKS (HOP_TICKS)
    ) dut (
        .clk_100 (clk_100),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 clk_100 = ~clk_100;

    // Behavioural model: plain integers, a queue, hop counter (-1 = no hop)
    int m_x, m_y, m_score, m_facing, m_hop, m_tx, m_ty;
    bit m_alive;
    int mq[$];

    function automatic void model_reset();
        m_x = START_X; m_y = 0; m_score = 0; m_facing = 0;
        m_hop = -1; m_tx = 0; m_ty = 0; m_alive = 1'b1;
        mq.delete();
    endfunction

    function automatic void model_step(input logic [2:0] mv, input logic [3:0] blk,
                                       input logic d, input logic rs);
        int  dir;
        int  nx;
        int  ny;
        bit  have;
        if (d) begin
            m_alive = 1'b0; m_hop = -1; mq.delete();
        end else if (rs) begin
            m_alive = 1'b1; m_hop = -1; mq.delete();
            m_x = START_X; m_y = 0; m_score = 0; m_facing = 0;
        end else if (!m_alive) begin
            // dead: nothing moves
        end else if (m_hop >= 0) begin
            if (QEN && mv[2] && mq.size() < 2) mq.push_back(int'(mv[1:0]));
            if (m_hop == HOP_TICKS - 1) begin
                m_x = m_tx; m_y = m_ty;
                if (m_y > m_score) m_score = m_y;
                if (m_score > 1023) m_score = 1023;
                m_hop = -1;
            end else begin
                m_hop++;
            end
        end else begin
            have = 1'b0;
            dir  = 0;
            if (mq.size() > 0) begin
                dir  = mq.pop_front();
                have = 1'b1;
                if (mv[2]) mq.push_back(int'(mv[1:0]));
            end else if (mv[2]) begin
                dir  = int'(mv[1:0]);
                have = 1'b1;
            end
            if (have) begin
                m_facing = dir;
                nx = m_x; ny = m_y;
                case (dir)
                    0: ny = ny + 1;
                    1: ny = ny - 1;
                    2: nx = nx - 1;
                    default: nx = nx + 1;
                endcase
                if (!blk[dir] && nx >= 0 && nx < COLS && ny >= 0 && ny <= 255) begin
                    m_hop = 0; m_tx = nx; m_ty = ny;
                end
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".pos_x"},  32'(bus.pos_x),  32'(m_x));
        chk({tag, ".pos_y"},  32'(bus.pos_y),  32'(m_y));
        chk({tag, ".facing"}, 32'(bus.facing), 32'(m_facing));
        chk({tag, ".active"}, 32'(bus.hop_active), (m_hop >= 0) ? 32'd1 : 32'd0);
        chk({tag, ".phase"},  32'(bus.hop_phase),  (m_hop >= 0) ? 32'(m_hop) : 32'd0);
        chk({tag, ".score"},  32'(bus.score),  32'(m_score));
        chk({tag, ".alive"},  32'(bus.alive),  32'(m_alive));
    endtask

    task automatic step(input logic [2:0] mv, input logic [3:0] blk,
                        input logic d, input logic rs, input string tag);
        bus.move = mv; bus.blocked = blk; bus.dead = d; bus.respawn = rs;
        @(posedge clk_100);
        model_step(mv, blk, d, rs);
        #1;
        bus.move = 3'b000; bus.blocked = 4'b0000; bus.dead = 1'b0; bus.respawn = 1'b0;
        check_model(tag);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(3'b000, 4'b0000, 1'b0, 1'b0, "idle");
    endtask

    task automatic hop(input logic [1:0] dir, input string tag);
        step({1'b1, dir}, 4'b0000, 1'b0, 1'b0, tag);
        idle(HOP_TICKS);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int px;
        int py;
        logic [2:0] mv;
        logic [3:0] blk;
        logic       d;
        logic       rs;

        bus.move = 3'b000; bus.blocked = 4'b0000; bus.dead = 1'b0; bus.respawn = 1'b0;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk_100);
        #1;
        chk("reset.pos_x",  32'(bus.pos_x), 32'd4);
        chk("reset.pos_y",  32'(bus.pos_y), 32'd0);
        chk("reset.facing", 32'(bus.facing), 32'd0);
        chk("reset.active", 32'(bus.hop_active), 32'd0);
        chk("reset.phase",  32'(bus.hop_phase), 32'd0);
        chk("reset.score",  32'(bus.score), 32'd0);
        chk("reset.alive",  32'(bus.alive), 32'd1);
        @(posedge clk_100);
        #1;
        rst_n = 1'b1;

        // Single hop up: 8 cycles active, then committed
        step(3'b100, 4'b0000, 1'b0, 1'b0, "h1.start");
        chk("h1.active0", 32'(bus.hop_active), 32'd1);
        idle(HOP_TICKS - 1);
        chk("h1.phase_last", 32'(bus.hop_phase), 32'd7);
        chk("h1.active_last", 32'(bus.hop_active), 32'd1);
        chk("h1.y_before", 32'(bus.pos_y), 32'd0);
        idle(1);
        chk("h1.pos_y",  32'(bus.pos_y), 32'd1);
        chk("h1.pos_x",  32'(bus.pos_x), 32'd4);
        chk("h1.score",  32'(bus.score), 32'd1);
        chk("h1.facing", 32'(bus.facing), 32'd0);
        chk("h1.active_end", 32'(bus.hop_active), 32'd0);

        // Edge rejections: right at x=8, down at y=0
        for (int i = 0; i < 4; i++) hop(2'b11, "right");
        hop(2'b01, "down");
        step(3'b111, 4'b0000, 1'b0, 1'b0, "edge.right");
        chk("edge.right.active", 32'(bus.hop_active), 32'd0);
        chk("edge.right.facing", 32'(bus.facing), 32'd3);
        chk("edge.right.x",      32'(bus.pos_x), 32'd8);
        step(3'b101, 4'b0000, 1'b0, 1'b0, "edge.down");
        chk("edge.down.active", 32'(bus.hop_active), 32'd0);
        chk("edge.down.facing", 32'(bus.facing), 32'd1);

        // Obstacle up, then released
        step(3'b100, 4'b0001, 1'b0, 1'b0, "blk.up");
        chk("blk.active", 32'(bus.hop_active), 32'd0);
        chk("blk.y",      32'(bus.pos_y), 32'd0);
        hop(2'b00, "blk.free");
        chk("blk.free.y", 32'(bus.pos_y), 32'd1);

        // Commands during a hop
        step(3'b000, 4'b0000, 1'b0, 1'b1, "respawn1");
        chk("respawn1.x", 32'(bus.pos_x), 32'd4);
        step(3'b100, 4'b0000, 1'b0, 1'b0, "q.up0");
        step(3'b100, 4'b0000, 1'b0, 1'b0, "q.up1");
        step(3'b110, 4'b0000, 1'b0, 1'b0, "q.left");
        step(3'b111, 4'b0000, 1'b0, 1'b0, "q.right");
        idle(40);
`ifdef PLAYER_MOVE_QUEUE_EN
        chk("q.final_y", 32'(bus.pos_y), 32'd2);
        chk("q.final_x", 32'(bus.pos_x), 32'd3);
`else
        chk("q.final_y", 32'(bus.pos_y), 32'd1);
        chk("q.final_x", 32'(bus.pos_x), 32'd4);
`endif

        // Death mid-hop, ignored move, respawn
        px = int'(bus.pos_x);
        py = int'(bus.pos_y);
        step(3'b100, 4'b0000, 1'b0, 1'b0, "d.start");
        idle(3);
        chk("d.phase3", 32'(bus.hop_phase), 32'd3);
        step(3'b000, 4'b0000, 1'b1, 1'b0, "d.dead");
        chk("d.alive",  32'(bus.alive), 32'd0);
        chk("d.active", 32'(bus.hop_active), 32'd0);
        chk("d.x", 32'(bus.pos_x), 32'(px));
        chk("d.y", 32'(bus.pos_y), 32'(py));
        step(3'b100, 4'b0000, 1'b0, 1'b0, "d.move");
        idle(HOP_TICKS + 1);
        chk("d.move.y",     32'(bus.pos_y), 32'(py));
        chk("d.move.alive", 32'(bus.alive), 32'd0);
        step(3'b000, 4'b0000, 1'b0, 1'b1, "d.respawn");
        chk("d.rs.x",     32'(bus.pos_x), 32'd4);
        chk("d.rs.y",     32'(bus.pos_y), 32'd0);
        chk("d.rs.score", 32'(bus.score), 32'd0);
        chk("d.rs.alive", 32'(bus.alive), 32'd1);

        // Score keeps the best row
        for (int i = 0; i < 5; i++) hop(2'b00, "up5");
        hop(2'b01, "dn1");
        hop(2'b01, "dn2");
        chk("sc.y",     32'(bus.pos_y), 32'd3);
        chk("sc.score", 32'(bus.score), 32'd5);

        // Asynchronous reset in the middle of a hop
        step(3'b100, 4'b0000, 1'b0, 1'b0, "rm.start");
        idle(2);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_model("rm.async");
        chk("rm.y",      32'(bus.pos_y), 32'd0);
        chk("rm.active", 32'(bus.hop_active), 32'd0);
        @(posedge clk_100);
        #1;
        check_model("rm.held");
        rst_n = 1'b1;
        idle(HOP_TICKS + 2);

        // Randomized run against the model
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 99) < 45) mv = {1'b1, 2'($urandom_range(0, 3))};
            else                            mv = {1'b0, 2'($urandom_range(0, 3))};
            blk = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            d   = ($urandom_range(0, 99) < 2);
            rs  = ($urandom_range(0, 99) < 3);
            step(mv, blk, d, rs, "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/player_move_ctrl.md
PLAYER_MOVE_CTRL -- requirements
Module: player_move_ctrl

Interface
REQ-001 Parameter COLS, default 9, sets the number of lane columns (x range 0..COLS-1, COLS<=16).
REQ-002 Parameter START_X, default 4, sets the x column after reset or respawn.
REQ-003 Parameter HOP_TICKS, default 8, sets hop duration in clk_100 cycles (2..16).
REQ-004 clk_100  in  1  system tick clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  reset; asynchronous, active-low.
REQ-006 move  in  3  move command pulse; bit2=valid, bits[1:0]: 00 up, 01 down, 10 left, 11 right; 3'b000 = none.
REQ-007 blocked  in  4  obstacle flags from the map, one per direction {right,left,down,up}, sampled only at hop start.
REQ-008 dead  in  1  collision/death level from the game core.
REQ-009 respawn  in  1  single-cycle restart pulse.
REQ-010 pos_x  out  4  current column.
REQ-011 pos_y  out  8  current row; 0 = start row, increases going up.
REQ-012 facing  out  2  last accepted direction, same encoding as move[1:0].
REQ-013 hop_active  out  1  high while a hop is in progress.
REQ-014 hop_phase  out  4  hop progress 0..HOP_TICKS-1; 0 when not hopping.
REQ-015 score  out  10  highest pos_y reached since reset/respawn, saturating.
REQ-016 alive  out  1  low in DEAD state.

Function
REQ-017 FSM states IDLE, HOP, DEAD SHALL be implemented.
REQ-018 IDLE: a command (from queue head, else move with move[2]=1) SHALL be evaluated the same cycle; facing SHALL update to its direction on the next edge.
REQ-019 A command SHALL be rejected (facing still updates, no hop, stay IDLE) if blocked[dir]=1, up at pos_y=255, down at pos_y=0, left at pos_x=0, or right at pos_x=COLS-1.
REQ-020 An accepted command SHALL enter HOP next edge with hop_phase=0, hop_active=1, and the target latched.
REQ-021 HOP: hop_phase SHALL increment each cycle; at hop_phase=HOP_TICKS-1 the next edge SHALL load pos_x/pos_y with the target, clear hop_active/hop_phase, and return to IDLE.
REQ-022 Move pulse to updated position latency SHALL be HOP_TICKS+1 cycles.
REQ-023 score SHALL update on the same edge as pos_y to max(score,pos_y), saturating at 1023.
REQ-024 dead=1 in any state SHALL enter DEAD next edge, abandoning any hop (position unchanged, queue flushed); dead has priority over every other event.
REQ-025 DEAD: move ignored, alive=0, all outputs held; respawn SHALL set pos_x=START_X, pos_y=0, score=0, facing=up, queue empty, state IDLE.
REQ-026 respawn in IDLE/HOP SHALL behave as in DEAD (restart), unless dead is also 1, in which case DEAD wins.
REQ-027 move with move[2]=0 SHALL be ignored in every state.

Reset
REQ-028 On rst_n low: state IDLE, pos_x=START_X, pos_y=0, facing=00, hop_active=0, hop_phase=0, score=0, alive=1, queue empty.
REQ-029 Reset mid-hop SHALL discard the hop with no position update.

Configuration
REQ-030 Macro PLAYER_MOVE_QUEUE_EN defined: a 2-entry FIFO SHALL store commands arriving during HOP; a command arriving when full SHALL be dropped; the head SHALL be popped and evaluated in the IDLE cycle after the hop ends, ahead of a same-cycle move input (which is then pushed).
REQ-031 Macro PLAYER_MOVE_QUEUE_EN undefined: no FIFO; commands arriving during HOP SHALL be dropped; IDLE evaluates only the move input.

Verification
REQ-032 Reset, move=3'b100 one cycle, blocked=0 -> hop_active high 8 cycles, then pos_y=1, pos_x=4, score=1, facing=00.
REQ-033 pos_x=8, move=3'b111 -> no hop, facing=11, pos_x stays 8; at pos_y=0, move=3'b101 -> no hop, facing=01.
REQ-034 blocked=4'b0001, move=3'b100 -> no hop, pos_y unchanged; release blocked, repeat -> pos_y+1.
REQ-035 With PLAYER_MOVE_QUEUE_EN: up, then up, left, right during the hop -> right dropped; final pos_y=2, pos_x=3 after three hops; without macro: only first hop, pos_y=1.
REQ-036 dead=1 at hop_phase=3 -> next cycle alive=0, hop_active=0, position unchanged; move ignored; respawn -> pos_x=4, pos_y=0, score=0, alive=1.
REQ-037 Up hops to pos_y=5, then down 2 -> pos_y=3, score stays 5.
